lcd_display_edge_pio: RTL and testbench
=======================================

// Module: lcd_display_edge_pio
// PURPOSE
//  Parametrised Avalon-MM input PIO for LCD status/keypad lines; successor to the fixed 16-bit input port.
//  Synchronises DATA_WIDTH asynchronous inputs, detects programmable edges into a sticky capture register,
//  and raises a maskable level interrupt. Sits between board pins and the Nios II data master.
// PARAMETERS
//  DATA_WIDTH   16  input port width, 1..32
//  SYNC_STAGES  2   flip-flop synchroniser depth, 2..4
//  EDGE_TYPE    0   0 = rising, 1 = falling, 2 = any edge
//  IRQ_RESET    0   reset value of irq_mask, DATA_WIDTH bits
// PORTS
//  clk        in   1           system clock
//  reset      in   1           synchronous reset, active-high
//  address    in   2           word address
//  chipselect in   1           slave select
//  write_n    in   1           active-low write strobe, qualified by chipselect
//  writedata  in   32          write data
//  in_port    in   DATA_WIDTH  asynchronous input pins
//  readdata   out  32          registered read data
//  irq        out  1           level interrupt request
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (reset); all state resets on the clk edge where reset=1.
//  Reset values: readdata=0, irq=0, sync chain=0, prev sample=0, edge_capture=0, irq_mask=IRQ_RESET.
//  Synchroniser: in_port passes through SYNC_STAGES flops; data_in is the last stage; prev is data_in delayed 1 cycle.
//  Edge detect per bit: rising = data_in & ~prev; falling = ~data_in & prev; any = data_in ^ prev.
//   Pin-to-capture latency is SYNC_STAGES+1 cycles.
//  Register map (unused upper readdata bits are 0):
//   0 DATA   RO  data_in (synchronised); writes are ignored.
//   1 MASK   RW  irq_mask <= writedata[DATA_WIDTH-1:0].
//   2 EDGE   R/W1C  sticky edge_capture; writing 1 clears that bit, and writing 0 leaves it unchanged.
//   3 RSVD   reads 0; writes are ignored.
//  Write: chipselect=1 and write_n=0 at a clk edge; the register updates on that edge.
//  Read: readdata <= mux(address) every cycle, independent of chipselect (1-cycle latency, no wait states).
//   Reading EDGE shows capture state from the previous cycle.
//  Set/clear collision: when an edge is detected on the same cycle as a W1C to that bit, set wins and the bit stays 1.
//  irq: registered; irq <= |(edge_capture_next & irq_mask_next); it asserts 1 cycle after a captured edge when masked in.
//   Clearing EDGE or MASK deasserts irq on the following edge.
//  Repeated edges on a bit that is already captured have no additional effect and are not counted.
//  Reset mid-operation: pending captures are lost, and irq drops on the reset edge.
//   On the first cycle after reset, prev=0, so an input held high produces one rising capture after sync;
//   this is the specified behaviour.
//  DATA_WIDTH<32: writedata bits above DATA_WIDTH are ignored.
// STRUCTURE
//  Package lcd_display_pio_pkg holds:
//   ADDR_DATA=2'd0, ADDR_MASK=2'd1, ADDR_EDGE=2'd2, ADDR_RSVD=2'd3;
//   EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2.
//  Sub-module lcd_display_sync_chain (params WIDTH, STAGES; synchronous active-high reset).
//   Instantiated once for in_port; everything else lives in the top.
// TESTING
//  1 Reset: hold reset 3 cycles with in_port=16'hFFFF -> readdata=0, irq=0;
//    MASK reads IRQ_RESET; EDGE reads 16'hFFFF after SYNC_STAGES+1 cycles (rising default).
//  2 Data path: in_port=16'hA5C3, read addr 0 -> readdata=32'h0000A5C3 by SYNC_STAGES+2 cycles after the change.
//  3 Edge+irq: MASK=16'h0001, pulse in_port[0] 0->1 -> EDGE bit0=1 and irq=1 one cycle later;
//    write EDGE=32'h1 -> EDGE=0, irq=0 next cycle.
//  4 Masking: edge on bit 5 with MASK=0 -> EDGE=16'h0020, irq stays 0;
//    write MASK=16'h0020 -> irq=1 next cycle.
//  5 Collision: edge on bit 3 arrives on the same cycle as a W1C of bit 3 -> EDGE bit3 remains 1 and irq stays asserted.
//  6 EDGE_TYPE=1 and EDGE_TYPE=2 builds: a 1->0 transition captures in both builds;
//    a 0->1 transition captures only in the EDGE_TYPE=2 (any) build.
//    Also, reset asserted mid-capture -> EDGE=0 and irq=0 on the reset edge.

Source files
------------

// File: rtl/lcd_display_pio_pkg.sv
// Shared register map and edge-type encodings for the LCD edge-capture PIO.
package lcd_display_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/lcd_display_sync_chain.sv
// Multi-flop synchroniser bringing asynchronous pins into the clk domain.
module lcd_display_sync_chain #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // Shift pins through STAGES flops; stage 0 is the metastability catcher.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/lcd_display_edge_pio.sv
// Avalon-MM input PIO: synchronised pins, sticky programmable edge capture,
// maskable level interrupt.
module lcd_display_edge_pio
    import lcd_display_pio_pkg::*;
#(
    parameter int          DATA_WIDTH  = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = EDGE_RISING,
    parameter logic [31:0] IRQ_RESET   = 32'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] edge_capture;
    logic [DATA_WIDTH-1:0] edge_capture_next;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] irq_mask_next;
    logic [DATA_WIDTH-1:0] w1c_bits;
    logic [31:0]           rd_mux;
    logic                  wr_en;
    logic                  unused_wdata;

    // Upper writedata bits only matter for wide builds.
    assign unused_wdata = ^writedata;

    lcd_display_sync_chain #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (in_port),
        .dout  (data_in)
    );

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign edge_det = ~data_in & prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_det = data_in ^ prev;
        end else begin : g_rise
            assign edge_det = data_in & ~prev;
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;

    // Next-state for mask and capture; a fresh edge beats a same-cycle W1C.
    always_comb begin
        irq_mask_next = irq_mask;
        w1c_bits      = '0;
        if (wr_en && address == ADDR_MASK) irq_mask_next = writedata[DATA_WIDTH-1:0];
        if (wr_en && address == ADDR_EDGE) w1c_bits      = writedata[DATA_WIDTH-1:0];
        edge_capture_next = (edge_capture & ~w1c_bits) | edge_det;
    end

    // Read mux over current register values, zero-extended to 32 bits.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[DATA_WIDTH-1:0] = data_in;
            ADDR_MASK: rd_mux[DATA_WIDTH-1:0] = irq_mask;
            ADDR_EDGE: rd_mux[DATA_WIDTH-1:0] = edge_capture;
            default:   rd_mux = '0;
        endcase
    end

    // Register state, read data and the level interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev         <= '0;
            edge_capture <= '0;
            irq_mask     <= IRQ_RESET[DATA_WIDTH-1:0];
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            prev         <= data_in;
            edge_capture <= edge_capture_next;
            irq_mask     <= irq_mask_next;
            readdata     <= rd_mux;
            irq          <= |(edge_capture_next & irq_mask_next);
        end
    end

endmodule

// File: tb/tb_lcd_display_edge_pio.sv
// Scoreboard bench: three builds (rising/falling/any) share one bus and pin
// set; a cycle-level reference model predicts readdata/irq after each edge.
module tb_lcd_display_edge_pio;

    localparam int NI = 3;
    localparam int ET [NI] = '{0, 1, 2};
    localparam int SS [NI] = '{2, 3, 2};
    localparam logic [15:0] IR [NI] = '{16'h0000, 16'h00F0, 16'h0000};

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [15:0] in_port;
    logic [31:0] rd [NI];
    logic        irq [NI];

    always #5 clk = ~clk;

    lcd_display_edge_pio #(.DATA_WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_RESET(32'h0000)) u0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq[0]));
    lcd_display_edge_pio #(.DATA_WIDTH(16), .SYNC_STAGES(3), .EDGE_TYPE(1), .IRQ_RESET(32'h00F0)) u1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq[1]));
    lcd_display_edge_pio #(.DATA_WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_RESET(32'h0000)) u2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq[2]));

    typedef struct packed {
        logic [NI-1:0][31:0] rd;
        logic [NI-1:0]       irq;
    } exp_t;

    exp_t exp_q [$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   done   = 1'b0;

    // Model state: pin samples per edge, newest at index 0
    logic [15:0] hist [NI][5];
    logic [15:0] m_mask [NI];
    logic [15:0] m_cap  [NI];

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic predict();
        exp_t e;
        logic [15:0] d, p, ed, clr, capn, mskn;
        bit wr;
        e  = '0;
        wr = chipselect && !write_n;
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                for (int i = 0; i < 5; i++) hist[k][i] = 16'h0;
                m_mask[k] = IR[k];
                m_cap[k]  = 16'h0;
            end else begin
                d = hist[k][SS[k]-1];
                p = hist[k][SS[k]];
                case (address)
                    2'd0: e.rd[k] = {16'h0, d};
                    2'd1: e.rd[k] = {16'h0, m_mask[k]};
                    2'd2: e.rd[k] = {16'h0, m_cap[k]};
                    default: e.rd[k] = 32'h0;
                endcase
                if (ET[k] == 0)      ed = d & ~p;
                else if (ET[k] == 1) ed = ~d & p;
                else                 ed = d ^ p;
                clr  = (wr && address == 2'd2) ? writedata[15:0] : 16'h0;
                mskn = (wr && address == 2'd1) ? writedata[15:0] : m_mask[k];
                capn = (m_cap[k] & ~clr) | ed;
                e.irq[k]  = |(capn & mskn);
                m_cap[k]  = capn;
                m_mask[k] = mskn;
                for (int i = 4; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = in_port;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic [15:0] pin, input logic [1:0] a,
                        input logic wr, input logic [31:0] wd);
        @(negedge clk);
        reset      = rst;
        in_port    = pin;
        address    = a;
        chipselect = wr ? 1'b1 : $urandom_range(0, 1);
        write_n    = ~wr;
        writedata  = wd;
        predict();
    endtask

    // Monitor: every cycle is an output beat; pop and compare.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < NI; k++) begin
                    n_chk++;
                    if (rd[k] === e.rd[k]) n_pass++;
                    else $display("FAIL readdata[u%0d] t=%0t got %h exp %h", k, $time, rd[k], e.rd[k]);
                    n_chk++;
                    if (irq[k] === e.irq[k]) n_pass++;
                    else $display("FAIL irq[u%0d] t=%0t got %b exp %b", k, $time, irq[k], e.irq[k]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pin;
        logic [1:0]  a;
        reset = 1'b1; in_port = 16'h0; address = 2'd0; chipselect = 1'b0;
        write_n = 1'b1; writedata = 32'h0;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 5; i++) hist[k][i] = 16'h0;
            m_mask[k] = IR[k]; m_cap[k] = 16'h0;
        end

        // Reset with pins high, then watch EDGE and MASK
        for (int i = 0; i < 3; i++) step(1, 16'hFFFF, 2'd2, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 16'hFFFF, 2'd2, 0, 0);
        step(0, 16'hFFFF, 2'd1, 0, 0);
        step(0, 16'hFFFF, 2'd2, 1, 32'hFFFF_FFFF);
        step(0, 16'hFFFF, 2'd3, 1, 32'h1234_5678);
        step(0, 16'hFFFF, 2'd0, 1, 32'h0000_0000);
        // Data path
        for (int i = 0; i < 6; i++) step(0, 16'hA5C3, 2'd0, 0, 0);
        // Clear, mask bit0, pulse bit0, then W1C
        pin = 16'h0000;
        step(0, pin, 2'd2, 1, 32'hFFFF);
        step(0, pin, 2'd1, 1, 32'h0001);
        for (int i = 0; i < 5; i++) step(0, pin, 2'd2, 1, 32'hFFFF);
        pin = 16'h0001;
        for (int i = 0; i < 6; i++) step(0, pin, 2'd2, 0, 0);
        step(0, pin, 2'd2, 1, 32'h1);
        for (int i = 0; i < 3; i++) step(0, pin, 2'd2, 0, 0);
        // Masking: edge on bit 5 with mask off, then enable
        step(0, pin, 2'd1, 1, 32'h0);
        pin = 16'h0021;
        for (int i = 0; i < 6; i++) step(0, pin, 2'd2, 0, 0);
        step(0, pin, 2'd1, 1, 32'hFFFF_0020);
        step(0, pin, 2'd2, 0, 0);
        // Collision: bit 3 edge lands with its W1C (depth-2 builds)
        step(0, pin, 2'd1, 1, 32'h0008);
        step(0, pin, 2'd2, 1, 32'hFFFF);
        for (int i = 0; i < 4; i++) step(0, pin, 2'd2, 0, 0);
        pin = 16'h0029;
        step(0, pin, 2'd2, 0, 0);
        step(0, pin, 2'd2, 0, 0);
        step(0, pin, 2'd2, 1, 32'h0008);
        for (int i = 0; i < 3; i++) step(0, pin, 2'd2, 0, 0);
        // Falling transition, then reset mid-capture
        pin = 16'h0020;
        for (int i = 0; i < 3; i++) step(0, pin, 2'd2, 0, 0);
        step(1, pin, 2'd2, 0, 0);
        for (int i = 0; i < 6; i++) step(0, pin, 2'd2, 0, 0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) pin = pin ^ 16'($urandom() & $urandom());
            a = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       step(1, pin, a, 0, 0);
                1, 2, 3: step(0, pin, a, 1, $urandom());
                default: step(0, pin, a, 0, $urandom());
            endcase
        end

        step(0, pin, 2'd0, 0, 0);
        @(posedge clk); #2;
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
